// File: rtl/reg_file_sb_if.sv
// Bus bundle for reg_file_sb: write ports, read ports, scoreboard and status.
// The master drives requests; the slave (the register file) returns data and status.
interface reg_file_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic            start;
  logic            wr0_en;
  logic [AW-1:0]   wr0_addr;
  logic [XLEN-1:0] wr0_data;
  logic            wr1_en;
  logic [AW-1:0]   wr1_addr;
  logic [XLEN-1:0] wr1_data;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            sb_set;
  logic [AW-1:0]   sb_addr;
  logic            rs1_busy;
  logic            rs2_busy;
  logic [XLEN-1:0] tap_data;
  logic            collide_err;

  modport master (
    output start, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           rs1_addr, rs2_addr, sb_set, sb_addr,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, tap_data, collide_err
  );

  modport slave (
    input  start, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           rs1_addr, rs2_addr, sb_set, sb_addr,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, tap_data, collide_err
  );
endinterface

// File: rtl/reg_file_sb.sv
// Two-write / two-read register file with write-to-read bypass, a busy
// scoreboard for multi-cycle results, a fixed debug tap and a sticky
// write-collision flag. Register 0 is hard-wired to zero and never busy.
module reg_file_sb #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int TAP_IDX = 18
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  reg_file_sb_if.slave bus
);
  localparam int            AW     = $clog2(NREGS);
  localparam logic [AW-1:0] ZERO_A = {AW{1'b0}};
  localparam logic [AW-1:0] TAP_A  = AW'(TAP_IDX);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic             collide_q, collide_d;

  // An operation only counts while out of reset and enabled; x0 targets are dropped.
  logic wr0_act_s, wr1_act_s, sb_act_s;
  assign wr0_act_s = reset_ni & bus.start & bus.wr0_en & (bus.wr0_addr != ZERO_A);
  assign wr1_act_s = reset_ni & bus.start & bus.wr1_en & (bus.wr1_addr != ZERO_A);
  assign sb_act_s  = reset_ni & bus.start & bus.sb_set & (bus.sb_addr  != ZERO_A);

  // Bypassed read: port 1 write beats port 0 write beats the stored value.
  function automatic logic [XLEN-1:0] rd_sel(
    input logic [AW-1:0]   addr,
    input logic [XLEN-1:0] arr_val
  );
    if (addr == ZERO_A) begin
      rd_sel = {XLEN{1'b0}};
    end else if (wr1_act_s && (bus.wr1_addr == addr)) begin
      rd_sel = bus.wr1_data;
    end else if (wr0_act_s && (bus.wr0_addr == addr)) begin
      rd_sel = bus.wr0_data;
    end else begin
      rd_sel = arr_val;
    end
  endfunction

  // Next-state for array, scoreboard and collision flag.
  always_comb begin
    regs_d    = regs_q;
    busy_d    = busy_q;
    collide_d = collide_q;
    for (int i = 1; i < NREGS; i++) begin
      if (wr1_act_s && (bus.wr1_addr == i[AW-1:0])) begin
        regs_d[i] = bus.wr1_data;
      end else if (wr0_act_s && (bus.wr0_addr == i[AW-1:0])) begin
        regs_d[i] = bus.wr0_data;
      end else begin
        regs_d[i] = regs_q[i];
      end
      // A new issue to the same register outranks the retiring result.
      if (sb_act_s && (bus.sb_addr == i[AW-1:0])) begin
        busy_d[i] = 1'b1;
      end else if (wr1_act_s && (bus.wr1_addr == i[AW-1:0])) begin
        busy_d[i] = 1'b0;
      end else begin
        busy_d[i] = busy_q[i];
      end
    end
    regs_d[0] = {XLEN{1'b0}};
    busy_d[0] = 1'b0;
    if (wr0_act_s && wr1_act_s && (bus.wr0_addr == bus.wr1_addr)) begin
      collide_d = 1'b1;
    end else begin
      collide_d = collide_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= {XLEN{1'b0}};
      end
      busy_q    <= {NREGS{1'b0}};
      collide_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      busy_q    <= busy_d;
      collide_q <= collide_d;
    end
  end

  assign bus.rs1_data    = rd_sel(bus.rs1_addr, regs_q[bus.rs1_addr]);
  assign bus.rs2_data    = rd_sel(bus.rs2_addr, regs_q[bus.rs2_addr]);
  assign bus.rs1_busy    = busy_q[bus.rs1_addr];
  assign bus.rs2_busy    = busy_q[bus.rs2_addr];
  assign bus.tap_data    = regs_q[TAP_A];
  assign bus.collide_err = collide_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: a 32x32 instance (tap x18) and a
// 64-bit x16 instance (tap x10) sharing clock and reset.
module tb_reg_file_sb;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  reg_file_sb_if #(.XLEN(32), .NREGS(32)) ifa ();
  reg_file_sb_if #(.XLEN(64), .NREGS(16)) ifb ();

  reg_file_sb #(.XLEN(32), .NREGS(32), .TAP_IDX(18)) u_a (
    .clk_i    (clk),
    .reset_ni (rst_n),
    .bus      (ifa.slave)
  );

  reg_file_sb #(.XLEN(64), .NREGS(16), .TAP_IDX(10)) u_b (
    .clk_i    (clk),
    .reset_ni (rst_n),
    .bus      (ifb.slave)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one full cycle: through the rising edge to the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_a();
    ifa.wr0_en = 1'b0;
    ifa.wr1_en = 1'b0;
    ifa.sb_set = 1'b0;
  endtask

  task automatic idle_b();
    ifb.wr0_en = 1'b0;
    ifb.wr1_en = 1'b0;
    ifb.sb_set = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    ifa.start = 1'b0; ifa.wr0_addr = 5'd0; ifa.wr0_data = 32'h0; ifa.wr1_addr = 5'd0;
    ifa.wr1_data = 32'h0; ifa.rs1_addr = 5'd0; ifa.rs2_addr = 5'd0; ifa.sb_addr = 5'd0;
    ifb.start = 1'b0; ifb.wr0_addr = 4'd0; ifb.wr0_data = 64'h0; ifb.wr1_addr = 4'd0;
    ifb.wr1_data = 64'h0; ifb.rs1_addr = 4'd0; ifb.rs2_addr = 4'd0; ifb.sb_addr = 4'd0;
    idle_a();
    idle_b();

    // Reset state
    #2;
    chk("rst_tap_a", {32'h0, ifa.tap_data}, 64'h0);
    chk("rst_collide_a", {63'h0, ifa.collide_err}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Same-cycle bypass, then array read after the first post-reset edge
    ifa.start = 1'b1; ifa.wr0_en = 1'b1; ifa.wr0_addr = 5'd5; ifa.wr0_data = 32'hDEADBEEF;
    ifa.rs1_addr = 5'd5;
    #1 chk("byp_x5", {32'h0, ifa.rs1_data}, 64'hDEADBEEF);
    tick(); idle_a();
    #1 chk("arr_x5", {32'h0, ifa.rs1_data}, 64'hDEADBEEF);

    // x0 ignores writes and reads zero even as a bypass target
    ifa.wr0_en = 1'b1; ifa.wr0_addr = 5'd0; ifa.wr0_data = 32'hFFFFFFFF; ifa.rs1_addr = 5'd0;
    #1 chk("byp_x0", {32'h0, ifa.rs1_data}, 64'h0);
    tick(); idle_a();
    #1 chk("arr_x0", {32'h0, ifa.rs1_data}, 64'h0);

    // Write collision on x7: port 1 wins, sticky error
    ifa.wr0_en = 1'b1; ifa.wr0_addr = 5'd7; ifa.wr0_data = 32'h11;
    ifa.wr1_en = 1'b1; ifa.wr1_addr = 5'd7; ifa.wr1_data = 32'h22; ifa.rs1_addr = 5'd7;
    #1 chk("byp_x7_p1", {32'h0, ifa.rs1_data}, 64'h22);
    chk("collide_pre", {63'h0, ifa.collide_err}, 64'h0);
    tick(); idle_a();
    #1 chk("arr_x7", {32'h0, ifa.rs1_data}, 64'h22);
    chk("collide_set", {63'h0, ifa.collide_err}, 64'h1);
    tick(); tick();
    chk("collide_sticky", {63'h0, ifa.collide_err}, 64'h1);

    // Scoreboard on x9
    ifa.sb_set = 1'b1; ifa.sb_addr = 5'd9; ifa.rs2_addr = 5'd9;
    #1 chk("busy_no_byp", {63'h0, ifa.rs2_busy}, 64'h0);
    tick(); idle_a();
    #1 chk("busy_set", {63'h0, ifa.rs2_busy}, 64'h1);
    ifa.wr1_en = 1'b1; ifa.wr1_addr = 5'd9; ifa.wr1_data = 32'hA5;
    #1 chk("busy_clr_pending", {63'h0, ifa.rs2_busy}, 64'h1);
    chk("byp_x9", {32'h0, ifa.rs2_data}, 64'hA5);
    tick(); idle_a();
    #1 chk("busy_clr", {63'h0, ifa.rs2_busy}, 64'h0);
    chk("arr_x9", {32'h0, ifa.rs2_data}, 64'hA5);
    ifa.sb_set = 1'b1; ifa.sb_addr = 5'd9;
    ifa.wr1_en = 1'b1; ifa.wr1_addr = 5'd9; ifa.wr1_data = 32'hB6;
    tick(); idle_a();
    #1 chk("busy_set_wins", {63'h0, ifa.rs2_busy}, 64'h1);
    chk("arr_x9_b6", {32'h0, ifa.rs2_data}, 64'hB6);
    ifa.wr0_en = 1'b1; ifa.wr0_addr = 5'd9; ifa.wr0_data = 32'hC7;
    ifa.sb_set = 1'b1; ifa.sb_addr = 5'd0; ifa.rs1_addr = 5'd0;
    tick(); idle_a();
    #1 chk("busy_wr0_keeps", {63'h0, ifa.rs2_busy}, 64'h1);
    chk("arr_x9_c7", {32'h0, ifa.rs2_data}, 64'hC7);
    chk("busy_x0", {63'h0, ifa.rs1_busy}, 64'h0);

    // start low freezes everything and disables bypass
    ifa.start = 1'b0; ifa.wr0_en = 1'b1; ifa.wr0_addr = 5'd3; ifa.wr0_data = 32'h55;
    ifa.sb_set = 1'b1; ifa.sb_addr = 5'd3; ifa.rs1_addr = 5'd3; ifa.rs2_addr = 5'd3;
    #1 chk("stop_no_byp", {32'h0, ifa.rs1_data}, 64'h0);
    tick();
    #1 chk("stop_x3", {32'h0, ifa.rs1_data}, 64'h0);
    chk("stop_busy3", {63'h0, ifa.rs2_busy}, 64'h0);
    chk("stop_collide", {63'h0, ifa.collide_err}, 64'h1);
    ifa.start = 1'b1;
    tick(); idle_a();
    #1 chk("go_x3", {32'h0, ifa.rs1_data}, 64'h55);
    chk("go_busy3", {63'h0, ifa.rs2_busy}, 64'h1);

    // Tap shows the array value, one cycle after the write
    ifa.wr0_en = 1'b1; ifa.wr0_addr = 5'd18; ifa.wr0_data = 32'h12345678;
    #1 chk("tap_same_cycle", {32'h0, ifa.tap_data}, 64'h0);
    tick(); idle_a();
    #1 chk("tap_after", {32'h0, ifa.tap_data}, 64'h12345678);

    // Populate both instances, then reset mid-operation
    ifb.start = 1'b1;
    for (int i = 1; i < 32; i++) begin
      ifa.wr0_en = 1'b1; ifa.wr0_addr = i[4:0]; ifa.wr0_data = 32'h1000_0000 + i;
      if (i < 16) begin
        ifb.wr0_en = 1'b1; ifb.wr0_addr = i[3:0]; ifb.wr0_data = 64'hA000_0000_0000_0000 + i;
      end else begin
        ifb.wr0_en = 1'b0;
      end
      tick();
    end
    idle_a(); idle_b();
    ifb.sb_set = 1'b1; ifb.sb_addr = 4'd4; ifb.wr0_en = 1'b1; ifb.wr0_addr = 4'd1;
    ifb.wr0_data = 64'h1;
    ifb.wr1_en = 1'b1; ifb.wr1_addr = 4'd1; ifb.wr1_data = 64'h2;
    tick(); idle_b();
    ifa.rs1_addr = 5'd31; ifa.rs2_addr = 5'd9;
    ifb.rs1_addr = 4'd15; ifb.rs2_addr = 4'd4;
    #1 chk("pop_a_x31", {32'h0, ifa.rs1_data}, 64'h1000_001F);
    chk("pop_a_tap", {32'h0, ifa.tap_data}, 64'h1000_0012);
    chk("pop_b_x15", ifb.rs1_data, 64'hA000_0000_0000_000F);
    chk("pop_b_tap", ifb.tap_data, 64'hA000_0000_0000_000A);
    chk("pop_b_busy4", {63'h0, ifb.rs2_busy}, 64'h1);
    chk("pop_b_collide", {63'h0, ifb.collide_err}, 64'h1);
    ifa.wr0_en = 1'b1; ifa.wr0_addr = 5'd31; ifa.wr0_data = 32'hCAFE_F00D;
    ifa.sb_set = 1'b1; ifa.sb_addr = 5'd31;
    #1 rst_n = 1'b0;
    #1 chk("rst_a_rs1", {32'h0, ifa.rs1_data}, 64'h0);
    chk("rst_a_rs2", {32'h0, ifa.rs2_data}, 64'h0);
    chk("rst_a_busy", {63'h0, ifa.rs2_busy}, 64'h0);
    chk("rst_a_tap", {32'h0, ifa.tap_data}, 64'h0);
    chk("rst_a_collide", {63'h0, ifa.collide_err}, 64'h0);
    chk("rst_b_rs1", ifb.rs1_data, 64'h0);
    chk("rst_b_busy", {63'h0, ifb.rs2_busy}, 64'h0);
    chk("rst_b_tap", ifb.tap_data, 64'h0);
    chk("rst_b_collide", {63'h0, ifb.collide_err}, 64'h0);
    tick(); idle_a();
    rst_n = 1'b1;
    ifa.rs2_addr = 5'd31;
    #1 chk("post_rst_x31", {32'h0, ifa.rs1_data}, 64'h0);
    chk("post_rst_busy31", {63'h0, ifa.rs2_busy}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
